// File: rtl/board_status_writer.sv
// board_status_writer
// Write-side engine for the 5x5 minesweeper board-status RAM read by the VGA path.
// Turns new presses into status writes (neighbour count, mine, hidden), clears
// the board, reveals every mine on game over and detects a win.
// Optional build macro: FLOOD_REVEAL_EN adds a FLOOD state that auto-reveals
// the region around any zero-count cell. Without it, one cell is revealed per press.
module board_status_writer #(
  parameter int         BOARD_W       = 5,
  parameter int         BOARD_H       = 5,
  parameter logic [3:0] STATUS_HIDDEN = 4'd10,
  parameter logic [3:0] STATUS_MINE   = 4'd9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       press,
  input  logic [31:0]                cursor_id,
  input  logic [BOARD_W*BOARD_H-1:0] mine_map,
  output logic                       wEn,
  output logic [31:0]                addr,
  output logic [31:0]                dataIn,
  output logic                       busy,
  output logic                       game_over,
  output logic                       game_won,
  output logic [4:0]                 revealed_count
);

  localparam int NCELLS = BOARD_W * BOARD_H;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_CHECK,
    S_MINE_SWEEP,
    S_DONE
`ifdef FLOOD_REVEAL_EN
    , S_FLOOD
`endif
  } state_t;

  // Mask of the in-board 8-neighbours of a cell; off-board cells never wrap.
  function automatic logic [NCELLS-1:0] nbr_mask(input logic [4:0] id);
    logic [NCELLS-1:0] m;
    int r, c, rr, cc;
    m = '0;
    r = int'(id) / BOARD_W;
    c = int'(id) % BOARD_W;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < BOARD_H && cc >= 0 && cc < BOARD_W)
          m[rr*BOARD_W + cc] = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic logic [4:0] popcount(input logic [NCELLS-1:0] v);
    logic [4:0] s;
    s = '0;
    for (int i = 0; i < NCELLS; i++) s = s + {4'd0, v[i]};
    return s;
  endfunction

  state_t            state, next_state;
  logic [4:0]        idx;
  logic [4:0]        cell_id;
  logic [NCELLS-1:0] revealed;
  logic              press_q;

  logic              new_press, cid_ok, idx_last, state_scans, busy_d;
  logic [4:0]        cid5, cell_sel, safe_total, count_inc;
  logic [NCELLS-1:0] sel_nbrs;
  logic [3:0]        sel_count;
  logic              w_en_d;
  logic [4:0]        w_addr_d;
  logic [3:0]        w_data_d;

`ifdef FLOOD_REVEAL_EN
  logic [NCELLS-1:0] zero_mask;
  logic              flood_any;
  logic              flood_hit;
`endif

  // Shared decode: press edge, cursor validity and neighbour count of the cell in focus.
  always_comb begin
    new_press   = press & ~press_q;
    cid_ok      = cursor_id < 32'(NCELLS);
    cid5        = cursor_id[4:0];
    idx_last    = (idx == 5'(NCELLS - 1));
    cell_sel    = (state == S_CHECK) ? cell_id : idx;
    sel_nbrs    = nbr_mask(cell_sel);
    sel_count   = 4'(popcount(sel_nbrs & mine_map));
    safe_total  = 5'(NCELLS) - popcount(mine_map);
    count_inc   = revealed_count + 5'd1;
    state_scans = (state == S_CLEAR) || (state == S_MINE_SWEEP);
`ifdef FLOOD_REVEAL_EN
    state_scans = state_scans || (state == S_FLOOD);
    flood_hit   = (state == S_FLOOD) && !revealed[idx] && !mine_map[idx] &&
                  (|(sel_nbrs & zero_mask));
`endif
    busy_d      = state_scans || (state == S_CHECK);
  end

  // State register; reset starts a board clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_CLEAR;
    else        state <= next_state;
  end

  // Next-state logic; clear overrides everything including a simultaneous press.
  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = S_CLEAR;
    end else begin
      case (state)
        S_CLEAR:      if (idx_last) next_state = S_IDLE;
        S_IDLE:       if (new_press && cid_ok && !revealed[cid5]) next_state = S_CHECK;
        S_CHECK: begin
          if (mine_map[cell_id])              next_state = S_MINE_SWEEP;
`ifdef FLOOD_REVEAL_EN
          else if (sel_count == 4'd0)         next_state = S_FLOOD;
`endif
          else if (count_inc == safe_total)   next_state = S_DONE;
          else                                next_state = S_IDLE;
        end
        S_MINE_SWEEP: if (idx_last) next_state = S_DONE;
`ifdef FLOOD_REVEAL_EN
        S_FLOOD: begin
          if (idx_last && !(flood_any || flood_hit)) begin
            if ((flood_hit ? count_inc : revealed_count) == safe_total) next_state = S_DONE;
            else                                                        next_state = S_IDLE;
          end
        end
`endif
        S_DONE:       next_state = S_DONE;
        default:      next_state = S_CLEAR;
      endcase
    end
  end

  // Write request for this cycle, registered onto wEn/addr/dataIn below.
  always_comb begin
    w_en_d   = 1'b0;
    w_addr_d = idx;
    w_data_d = STATUS_HIDDEN;
    if (!clear) begin
      case (state)
        S_CLEAR: w_en_d = 1'b1;
        S_CHECK: begin
          w_en_d   = 1'b1;
          w_addr_d = cell_id;
          w_data_d = mine_map[cell_id] ? STATUS_MINE : sel_count;
        end
        S_MINE_SWEEP: begin
          w_en_d   = mine_map[idx];
          w_data_d = STATUS_MINE;
        end
`ifdef FLOOD_REVEAL_EN
        S_FLOOD: begin
          w_en_d   = flood_hit;
          w_data_d = sel_count;
        end
`endif
        default: w_en_d = 1'b0;
      endcase
    end
  end

  // Registered outputs, scan index, latched cell and game bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      press_q        <= 1'b0;
      wEn            <= 1'b0;
      addr           <= '0;
      dataIn         <= '0;
      busy           <= 1'b0;
      idx            <= '0;
      cell_id        <= '0;
      revealed       <= '0;
      revealed_count <= '0;
      game_over      <= 1'b0;
      game_won       <= 1'b0;
    end else begin
      press_q <= press;
      wEn     <= w_en_d;
      addr    <= {27'd0, w_addr_d};
      dataIn  <= {28'd0, w_data_d};
      busy    <= busy_d;
      if (state_scans && !clear) idx <= idx_last ? 5'd0 : idx + 5'd1;
      else                       idx <= 5'd0;
      if (state == S_IDLE && next_state == S_CHECK) cell_id <= cid5;
      if (clear || state == S_CLEAR) begin
        revealed       <= '0;
        revealed_count <= '0;
        game_over      <= 1'b0;
        game_won       <= 1'b0;
      end else begin
        if (state == S_CHECK) begin
          if (mine_map[cell_id]) begin
            game_over <= 1'b1;
          end else begin
            revealed[cell_id] <= 1'b1;
            revealed_count    <= count_inc;
          end
        end
`ifdef FLOOD_REVEAL_EN
        if (flood_hit) begin
          revealed[idx]  <= 1'b1;
          revealed_count <= count_inc;
        end
`endif
        if (next_state == S_DONE && state != S_DONE && state != S_MINE_SWEEP)
          game_won <= 1'b1;
      end
    end
  end

`ifdef FLOOD_REVEAL_EN
  // Zero-count mask seeds the flood; flood_any remembers whether the current pass revealed anything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zero_mask <= '0;
      flood_any <= 1'b0;
    end else begin
      if (clear || state == S_CLEAR) begin
        zero_mask <= '0;
      end else if (state == S_CHECK && !mine_map[cell_id] && sel_count == 4'd0) begin
        zero_mask[cell_id] <= 1'b1;
      end else if (flood_hit && sel_count == 4'd0) begin
        zero_mask[idx] <= 1'b1;
      end
      if (state == S_FLOOD && !clear) flood_any <= idx_last ? 1'b0 : (flood_any | flood_hit);
      else                            flood_any <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_board_status_writer.sv
// tb_board_status_writer
// Directed, table-driven bench for board_status_writer with hand-computed expectations.
// Compile with +define+FLOOD_REVEAL_EN to exercise the flood-reveal build.
module tb_board_status_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        press = 1'b0;
  logic [31:0] cursor_id = '0;
  logic [24:0] mine_map = '0;
  logic        wEn, busy, game_over, game_won;
  logic [31:0] addr, dataIn;
  logic [4:0]  revealed_count;

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t wq[$];

  typedef struct {
    int          id;
    int          nwr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] cnt;
  } vec_t;
  vec_t vecs[8];

  board_status_writer dut (
    .clk(clk), .reset(reset), .clear(clear), .press(press),
    .cursor_id(cursor_id), .mine_map(mine_map),
    .wEn(wEn), .addr(addr), .dataIn(dataIn), .busy(busy),
    .game_over(game_over), .game_won(game_won), .revealed_count(revealed_count)
  );

  always #10 clk = ~clk;

  // Capture every RAM write away from the active edge.
  always @(negedge clk) begin
    if (reset && wEn) wq.push_back('{a: addr, d: dataIn});
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    step(3);
    while (busy && n < budget) begin
      step(1);
      n++;
    end
    checkOutput("idle_timeout_busy", {31'd0, busy}, 32'd0);
    step(1);
  endtask

  task automatic applyStimulus(input int id, input int budget);
    cursor_id = id;
    press = 1'b1;
    step(1);
    press = 1'b0;
    waitIdle(budget);
  endtask

  task automatic doClear();
    wq.delete();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    waitIdle(100);
    checkOutput("clear_write_count", wq.size(), 32'd25);
    for (int i = 0; i < wq.size(); i++) begin
      checkOutput($sformatf("clear_addr_%0d", i), wq[i].a, i);
      checkOutput($sformatf("clear_data_%0d", i), wq[i].d, 32'd10);
    end
    checkOutput("clear_game_over", {31'd0, game_over}, 32'd0);
    checkOutput("clear_count", {27'd0, revealed_count}, 32'd0);
  endtask

  initial begin
    logic [24:0] seen;
    logic [31:0] expd;

    vecs[0] = '{id: 6,  nwr: 0, a: 0,  d: 0, cnt: 1};
    vecs[1] = '{id: 30, nwr: 0, a: 0,  d: 0, cnt: 1};
    vecs[2] = '{id: 2,  nwr: 1, a: 2,  d: 1, cnt: 2};
    vecs[3] = '{id: 18, nwr: 1, a: 18, d: 1, cnt: 3};
    vecs[4] = '{id: 11, nwr: 1, a: 11, d: 2, cnt: 4};
    vecs[5] = '{id: 25, nwr: 0, a: 0,  d: 0, cnt: 4};
    vecs[6] = '{id: 13, nwr: 1, a: 13, d: 2, cnt: 5};
    vecs[7] = '{id: 3,  nwr: 1, a: 3,  d: 1, cnt: 6};

    // Reset state and the power-up clear sequence.
    mine_map = 25'h0001080;
    step(2);
    checkOutput("reset_wEn", {31'd0, wEn}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_addr", addr, 32'd0);
    checkOutput("reset_data", dataIn, 32'd0);
    checkOutput("reset_flags", {29'd0, game_over, game_won, 1'b0}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step(1);
      checkOutput($sformatf("init_wEn_busy_%0d", i), {30'd0, wEn, busy}, 32'd3);
      checkOutput($sformatf("init_addr_%0d", i), addr, i);
      checkOutput($sformatf("init_data_%0d", i), dataIn, 32'd10);
    end
    step(1);
    checkOutput("init_done_wEn_busy", {30'd0, wEn, busy}, 32'd0);
    checkOutput("init_done_flags", {30'd0, game_over, game_won}, 32'd0);
    checkOutput("init_done_count", {27'd0, revealed_count}, 32'd0);

    // Exact write latency for a first safe press on id 6 (mines at 7 and 12).
    wq.delete();
    cursor_id = 6;
    press = 1'b1;
    step(1);
    press = 1'b0;
    checkOutput("lat_check_wEn", {31'd0, wEn}, 32'd0);
    step(1);
    checkOutput("lat_write_wEn_busy", {30'd0, wEn, busy}, 32'd3);
    checkOutput("lat_write_addr", addr, 32'd6);
    checkOutput("lat_write_data", dataIn, 32'd2);
    step(1);
    checkOutput("lat_after_wEn_busy", {30'd0, wEn, busy}, 32'd0);
    checkOutput("lat_after_count", {27'd0, revealed_count}, 32'd1);

    // Table of single presses: repeats and out-of-range ids write nothing.
    for (int v = 0; v < 8; v++) begin
      wq.delete();
      applyStimulus(vecs[v].id, 100);
      checkOutput($sformatf("vec%0d_nwrites", v), wq.size(), vecs[v].nwr);
      if (wq.size() == 1 && vecs[v].nwr == 1) begin
        checkOutput($sformatf("vec%0d_addr", v), wq[0].a, vecs[v].a);
        checkOutput($sformatf("vec%0d_data", v), wq[0].d, vecs[v].d);
      end
      checkOutput($sformatf("vec%0d_count", v), {27'd0, revealed_count}, vecs[v].cnt);
      checkOutput($sformatf("vec%0d_over", v), {31'd0, game_over}, 32'd0);
    end

    // Press held high across many cycles, cursor moved while held: one reveal only.
    wq.delete();
    cursor_id = 8;
    press = 1'b1;
    step(8);
    cursor_id = 16;
    step(5);
    press = 1'b0;
    waitIdle(100);
    checkOutput("held_nwrites", wq.size(), 32'd1);
    if (wq.size() > 0) begin
      checkOutput("held_addr", wq[0].a, 32'd8);
      checkOutput("held_data", wq[0].d, 32'd2);
    end
    checkOutput("held_count", {27'd0, revealed_count}, 32'd7);

    // Mine press: mine write then sweep over both mines, then presses are ignored.
    wq.delete();
    applyStimulus(12, 100);
    checkOutput("mine_nwrites", wq.size(), 32'd3);
    if (wq.size() == 3) begin
      checkOutput("mine_w0_addr", wq[0].a, 32'd12);
      checkOutput("mine_w0_data", wq[0].d, 32'd9);
      checkOutput("mine_w1_addr", wq[1].a, 32'd7);
      checkOutput("mine_w1_data", wq[1].d, 32'd9);
      checkOutput("mine_w2_addr", wq[2].a, 32'd12);
      checkOutput("mine_w2_data", wq[2].d, 32'd9);
    end
    checkOutput("mine_flags", {30'd0, game_over, game_won}, 32'd2);
    checkOutput("mine_count", {27'd0, revealed_count}, 32'd7);
    wq.delete();
    applyStimulus(4, 100);
    checkOutput("done_press_nwrites", wq.size(), 32'd0);
    checkOutput("done_press_over", {31'd0, game_over}, 32'd1);

    // Clear aborts a mine sweep in progress.
    doClear();
    wq.delete();
    cursor_id = 7;
    press = 1'b1;
    step(1);
    press = 1'b0;
    step(2);
    checkOutput("abort_over_set", {31'd0, game_over}, 32'd1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    checkOutput("abort_over_cleared", {31'd0, game_over}, 32'd0);
    waitIdle(100);
    checkOutput("abort_nwrites", wq.size(), 32'd26);
    if (wq.size() == 26) begin
      checkOutput("abort_w0_addr", wq[0].a, 32'd7);
      checkOutput("abort_w0_data", wq[0].d, 32'd9);
      for (int i = 1; i < 26; i++) begin
        checkOutput($sformatf("abort_clr_addr_%0d", i - 1), wq[i].a, i - 1);
        checkOutput($sformatf("abort_clr_data_%0d", i - 1), wq[i].d, 32'd10);
      end
    end
    checkOutput("abort_over_final", {31'd0, game_over}, 32'd0);

    // Win with a single mine at cell 0.
    mine_map = 25'h0000001;
    doClear();
    wq.delete();
`ifdef FLOOD_REVEAL_EN
    applyStimulus(24, 2000);
`else
    for (int id = 1; id < 25; id++) begin
      if (id == 24) checkOutput("win_not_yet", {31'd0, game_won}, 32'd0);
      applyStimulus(id, 100);
    end
`endif
    checkOutput("win_nwrites", wq.size(), 32'd24);
    seen = '0;
    for (int i = 0; i < wq.size(); i++) begin
      expd = (wq[i].a == 1 || wq[i].a == 5 || wq[i].a == 6) ? 32'd1 : 32'd0;
      checkOutput($sformatf("win_data_at_%0d", wq[i].a), wq[i].d, expd);
      if (wq[i].a < 25) seen[wq[i].a[4:0]] = 1'b1;
    end
    checkOutput("win_cells_written", {7'd0, seen}, 32'h1FFFFFE);
    checkOutput("win_flags", {30'd0, game_over, game_won}, 32'd1);
    checkOutput("win_count", {27'd0, revealed_count}, 32'd24);
    wq.delete();
    applyStimulus(0, 100);
    checkOutput("win_done_nwrites", wq.size(), 32'd0);
    checkOutput("win_done_flags", {30'd0, game_over, game_won}, 32'd1);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/board_status_writer.md
Name: board_status_writer

Overview:
Write-side engine for the 5x5 minesweeper board-status RAM that the VGA path reads every frame. It accepts the cursor cell id and the sticky "pressed" flag from the display/controller side. It turns each new press into status-word writes: neighbour count, mine, or hidden. It also owns board clearing, the game-over mine reveal and win detection.

Parameters:
BOARD_W, 5, cells per row
BOARD_H, 5, cells per column; NCELLS = BOARD_W*BOARD_H (25)
STATUS_HIDDEN, 10, status code for an unrevealed cell (drawn black)
STATUS_MINE, 9, status code for a revealed mine (drawn red)

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-low reset
clear  in  1  sync pulse: restart board
press  in  1  level/sticky press flag from display controller
cursor_id  in  32  cell id under cursor (row*5+col)
mine_map  in  25  bit i = cell i holds a mine; stable during a game
wEn  out  1  board RAM write strobe, one cycle per write
addr  out  32  board RAM write address, upper bits zero
dataIn  out  32  write data, status in [3:0], [31:4] zero
busy  out  1  FSM not in IDLE/DONE
game_over  out  1  mine revealed
game_won  out  1  all non-mine cells revealed
revealed_count  out  5  number of revealed safe cells

Behaviour:
- Reset (reset=0): all outputs 0. State=CLEAR, scan index 0, revealed mask 0, press_q 0.
- Write outputs are registered. wEn is high exactly one cycle per write. addr/dataIn are valid in the same cycle.
- Press detect: a new press is press=1 & press_q=0, with press_q <= press every cycle. Edges arriving while busy or in DONE are dropped, not queued.
- States: CLEAR, IDLE, CHECK, MINE_SWEEP, DONE, plus FLOOD when the optional feature is enabled.
- CLEAR: one write per cycle, addr 0..24, data STATUS_HIDDEN. That is 25 consecutive wEn cycles. Clears the revealed mask, revealed_count, game_over and game_won. Then goes to IDLE.
- clear=1 in any state enters CLEAR at index 0 on the next edge. This aborts any operation in progress. clear beats a simultaneous press.
- IDLE, new press at cycle T:
  - cursor_id >= 25, or the cell is already revealed: ignored, no write.
  - Otherwise the id is latched and the FSM enters CHECK at T+1.
- CHECK, write issued at T+2:
  - Mine: write STATUS_MINE at id, set game_over, enter MINE_SWEEP.
  - Safe: write n = popcount of in-board 8-neighbours in mine_map (0..8), set the revealed bit, increment revealed_count.
- Neighbour count: edges and corners exclude off-board cells. No wrap between rows or columns.
- Win check, evaluated after each safe write: if revealed_count == 25 - popcount(mine_map), set game_won and enter DONE. Otherwise return to IDLE.
- MINE_SWEEP: scan 0..24, one cell per cycle. Write STATUS_MINE only for cells whose mine_map bit is set. Then enter DONE.
- DONE: holds game_over/game_won and ignores presses until clear.
- busy = 1 in CLEAR, CHECK, MINE_SWEEP and FLOOD.

Optional Feature:
Macro: FLOOD_REVEAL_EN.
- Enabled: a safe write with n=0 enters FLOOD instead of the win check.
  - FLOOD repeats passes over cells 0..24, one cell per cycle.
  - Each unrevealed non-mine cell with a revealed zero-count neighbour is written with its count, marked revealed, and revealed_count is incremented.
  - A zero-count mask register is kept for this test.
  - Passes repeat until a full pass reveals nothing. The win check then applies.
- Disabled: the FLOOD state and zero mask are not built. Exactly one cell is revealed per press.

Test Plan:
1. Release reset with clear=0 -> 25 writes, addr 0..24, data 10, on consecutive cycles; busy=1 throughout, then 0; all flags 0.
2. mine_map bits 7 and 12 set; press rises with cursor_id=6 -> single write addr 6 data 2, two cycles after edge sample; revealed_count=1, busy back to 0.
3. Same map, press on id 12 -> write addr 12 data 9, then sweep writes addr 7 data 9 and addr 12 data 9; game_over=1; later press edges produce no wEn.
4. Re-press id 6 after press drops -> no write. cursor_id=30 -> no write. press held high across cycles -> only one reveal.
5. mine_map=bit 0 only:
   - Without FLOOD_REVEAL_EN, reveal all 24 safe ids -> game_won=1 after the 24th write, revealed_count=24.
   - With the macro, a single press on id 24 -> all 24 safe cells written (ids 1, 5, 6 data 1; others 0); game_won=1.
6. Assert clear during MINE_SWEEP -> sweep aborts next cycle; 25 writes of data 10 follow; game_over=0.
